// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: requesting side of the ALU operation interface.
// Takes one decoded operation from decode, presents it to the ALU until the
// ALU stops stalling (or a stall timeout expires), captures the ALU's
// registered result and hands it to writeback with its destination tag.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid and ready are both 1. Valid, once raised, is held with stable payload
// until that edge; ready never depends combinationally on the partner's valid.
module alu_issue_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   // decode side
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [2:0]  i_req_op_mode,
   input  logic [2:0]  i_req_func_op,
   input  logic [31:0] i_req_a,
   input  logic [31:0] i_req_b,
   input  logic [4:0]  i_req_rd,
   // ALU side
   output logic [2:0]  o_alu_op_mode,
   output logic [2:0]  o_alu_func_op,
   output logic        o_alu_fp_mode,
   output logic        o_alu_hold,
   output logic [31:0] o_alu_a,
   output logic [31:0] o_alu_b,
   input  logic        i_alu_stall,
   input  logic [31:0] i_alu_result,
   // writeback side
   output logic        o_wb_valid,
   input  logic        i_wb_ready,
   output logic [31:0] o_wb_result,
   output logic [4:0]  o_wb_rd,
   output logic        o_wb_err,
   output logic        o_timeout_seen,
   // debug view of the controller state
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_CAPT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Counter value at which a still-stalling operation is abandoned.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [2:0]  func_q, func_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [4:0]  rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [31:0] wb_result_q, wb_result_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic        wb_err_q, wb_err_d;
   logic        timeout_seen_q, timeout_seen_d;

   // Next-state and latched-field update for the issue sequence.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      func_d         = func_q;
      a_d            = a_q;
      b_d            = b_q;
      rd_d           = rd_q;
      cnt_d          = cnt_q;
      err_d          = err_q;
      wb_result_d    = wb_result_q;
      wb_rd_d        = wb_rd_q;
      wb_err_d       = wb_err_q;
      timeout_seen_d = timeout_seen_q;
      case (state_q)
         ST_IDLE: begin
            if (i_req_valid) begin
               op_d    = i_req_op_mode;
               func_d  = i_req_func_op;
               a_d     = i_req_a;
               b_d     = i_req_b;
               rd_d    = i_req_rd;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // A stall that drops in the limit cycle still counts as completion.
            if (!i_alu_stall) begin
               state_d = ST_CAPT;
            end else if (cnt_q == CNT_LAST) begin
               err_d          = 1'b1;
               timeout_seen_d = 1'b1;
               state_d        = ST_CAPT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_CAPT: begin
            // The ALU registered its result at the edge that ended EXEC.
            wb_result_d = err_q ? 32'd0 : i_alu_result;
            wb_rd_d     = rd_q;
            wb_err_d    = err_q;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (i_wb_ready) begin
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q        <= ST_IDLE;
         op_q           <= '0;
         func_q         <= '0;
         a_q            <= '0;
         b_q            <= '0;
         rd_q           <= '0;
         cnt_q          <= '0;
         err_q          <= 1'b0;
         wb_result_q    <= '0;
         wb_rd_q        <= '0;
         wb_err_q       <= 1'b0;
         timeout_seen_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         func_q         <= func_d;
         a_q            <= a_d;
         b_q            <= b_d;
         rd_q           <= rd_d;
         cnt_q          <= cnt_d;
         err_q          <= err_d;
         wb_result_q    <= wb_result_d;
         wb_rd_q        <= wb_rd_d;
         wb_err_q       <= wb_err_d;
         timeout_seen_q <= timeout_seen_d;
      end
   end

   // Per-state interface outputs; the ALU only sees a real op during EXEC so
   // its mul/div start detection re-arms between back-to-back operations.
   always_comb begin
      o_req_ready   = 1'b0;
      o_alu_op_mode = 3'd0;
      o_alu_func_op = 3'd0;
      o_alu_a       = 32'd0;
      o_alu_b       = 32'd0;
      o_alu_hold    = 1'b0;
      o_wb_valid    = 1'b0;
      case (state_q)
         ST_IDLE: o_req_ready = i_rst_n;
         ST_EXEC: begin
            o_alu_op_mode = op_q;
            o_alu_func_op = func_q;
            o_alu_a       = a_q;
            o_alu_b       = b_q;
         end
         ST_RESP: begin
            o_alu_hold = 1'b1;
            o_wb_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_alu_fp_mode  = 1'b0;
   assign o_wb_result    = wb_result_q;
   assign o_wb_rd        = wb_rd_q;
   assign o_wb_err       = wb_err_q;
   assign o_timeout_seen = timeout_seen_q;
   assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: ALU behavioural model plus scenario tasks.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [2:0]  req_fn = 3'd0;
   logic [31:0] req_a = 32'd0;
   logic [31:0] req_b = 32'd0;
   logic [4:0]  req_rd = 5'd0;
   logic [2:0]  alu_op_mode, alu_func_op;
   logic        alu_fp_mode, alu_hold;
   logic [31:0] alu_a, alu_b;
   logic        alu_stall;
   logic [31:0] alu_res_m = 32'd0;
   logic        wb_valid;
   logic        wb_ready = 1'b1;
   logic [31:0] wb_result;
   logic [4:0]  wb_rd;
   logic        wb_err, timeout_seen;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   // clock / reset block
   always #5 clk = ~clk;

   alu_issue_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_op_mode(req_op), .i_req_func_op(req_fn),
      .i_req_a(req_a), .i_req_b(req_b), .i_req_rd(req_rd),
      .o_alu_op_mode(alu_op_mode), .o_alu_func_op(alu_func_op),
      .o_alu_fp_mode(alu_fp_mode), .o_alu_hold(alu_hold),
      .o_alu_a(alu_a), .o_alu_b(alu_b),
      .i_alu_stall(alu_stall), .i_alu_result(alu_res_m),
      .o_wb_valid(wb_valid), .i_wb_ready(wb_ready),
      .o_wb_result(wb_result), .o_wb_rd(wb_rd), .o_wb_err(wb_err),
      .o_timeout_seen(timeout_seen), .o_dbg_state(dbg_state)
   );

   // Reference ALU function.
   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [2:0] fn,
                                           input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd1: case (fn)
                  3'd0: return a & b;
                  3'd1: return a | b;
                  3'd2: return a ^ b;
                  default: return ~a;
               endcase
         3'd2: return a << b[4:0];
         3'd3: return {31'd0, (a < b)};
         3'd4: return fn[0] ? a - b : a + b;
         3'd5: return a * b;
         3'd6: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default: return a;
      endcase
   endfunction

   // ALU model: mul/div stall for stall_target cycles (or forever when stuck);
   // result registered whenever not stalled and not held.
   int stall_target = 0;
   int stall_seen = 0;
   bit stuck = 1'b0;
   assign alu_stall = stuck || (((alu_op_mode == 3'd5) || (alu_op_mode == 3'd6)) &&
                                (stall_seen < stall_target));
   always @(posedge clk) begin
      if (alu_op_mode == 3'd0) stall_seen <= 0;
      else if (alu_stall) stall_seen <= stall_seen + 1;
      if (!alu_hold && !alu_stall)
         alu_res_m <= ref_alu(alu_op_mode, alu_func_op, alu_a, alu_b);
   end

   // Observations recorded by the driver task.
   int          lat_o;
   logic [31:0] res_o;
   logic [4:0]  rd_o;
   logic        err_o;
   int          ready_hi;
   int          bp_bad;
   logic        post_valid, post_ready;
   logic [2:0]  opm_tr [0:63];
   logic        hold_tr [0:63];

   // Driver: issue one op, follow it to writeback, optionally backpressure.
   // Cycle 0 is the cycle in which the request is accepted.
   task automatic do_op(input logic [2:0] op, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int stalls,
                        input bit stk, input int bp);
      int w;
      stall_target = stalls;
      stuck = stk;
      wb_ready = (bp == 0);
      lat_o = -1; ready_hi = 0; bp_bad = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_fn = fn; req_a = a; req_b = b; req_rd = rd;
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (req_ready) begin
         for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            opm_tr[k] = alu_op_mode;
            hold_tr[k] = alu_hold;
            if (wb_valid) begin
               lat_o = k; res_o = wb_result; rd_o = wb_rd; err_o = wb_err;
               break;
            end
            if (req_ready) ready_hi++;
         end
      end
      req_valid = 1'b0;
      if (lat_o > 0) begin
         for (int j = 0; j < bp; j++) begin
            @(negedge clk);
            if (!wb_valid || wb_result !== res_o || wb_rd !== rd_o || !alu_hold) bp_bad++;
         end
         wb_ready = 1'b1;
         @(negedge clk);
         post_valid = wb_valid;
         post_ready = req_ready;
      end
      stuck = 1'b0;
      stall_target = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
      checks++; if ({alu_op_mode, alu_func_op, alu_a, alu_b} !== 70'd0) begin errors++; $display("FAIL rst_alu got op=%0d fn=%0d a=%0h b=%0h exp all 0", alu_op_mode, alu_func_op, alu_a, alu_b); end
      checks++; if ({alu_hold, alu_fp_mode, wb_valid, wb_err, timeout_seen} !== 5'd0) begin errors++; $display("FAIL rst_flags got hold=%b fp=%b v=%b err=%b to=%b exp 0", alu_hold, alu_fp_mode, wb_valid, wb_err, timeout_seen); end
      checks++; if ({wb_result, wb_rd} !== 37'd0) begin errors++; $display("FAIL rst_wb got res=%0h rd=%0d exp 0", wb_result, wb_rd); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_first_idle_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_add();
      do_op(3'd4, 3'd0, 32'd5, 32'd7, 5'd3, 0, 1'b0, 0);
      checks++; if (lat_o !== 3) begin errors++; $display("FAIL add_lat got %0d exp 3", lat_o); end
      checks++; if (res_o !== 32'd12) begin errors++; $display("FAIL add_res got %0d exp 12", res_o); end
      checks++; if (rd_o !== 5'd3 || err_o !== 1'b0) begin errors++; $display("FAIL add_rd_err got rd=%0d err=%b exp rd=3 err=0", rd_o, err_o); end
      checks++; if (ready_hi !== 0) begin errors++; $display("FAIL add_ready_busy got %0d cycles high exp 0", ready_hi); end
      checks++; if (opm_tr[1] !== 3'd4 || opm_tr[2] !== 3'd0) begin errors++; $display("FAIL add_opmode got %0d,%0d exp 4,0", opm_tr[1], opm_tr[2]); end
      checks++; if (post_valid !== 1'b0 || post_ready !== 1'b1) begin errors++; $display("FAIL add_release got v=%b rdy=%b exp v=0 rdy=1", post_valid, post_ready); end
   endtask

   task automatic test_mul_stall();
      int n5;
      do_op(3'd5, 3'd0, 32'd6, 32'd7, 5'd9, 4, 1'b0, 0);
      n5 = 0;
      for (int k = 1; k <= 5; k++) if (opm_tr[k] == 3'd5) n5++;
      checks++; if (lat_o !== 7) begin errors++; $display("FAIL mul_lat got %0d exp 7", lat_o); end
      checks++; if (res_o !== 32'd42 || rd_o !== 5'd9) begin errors++; $display("FAIL mul_res got %0d rd=%0d exp 42 rd=9", res_o, rd_o); end
      checks++; if (n5 !== 5 || opm_tr[6] !== 3'd0) begin errors++; $display("FAIL mul_opmode got %0d cycles of 5, capt=%0d exp 5 cycles, capt=0", n5, opm_tr[6]); end
   endtask

   task automatic test_back_to_back();
      int acc [0:1];
      logic [31:0] got_res [0:1];
      logic [4:0] got_rd [0:1];
      logic [2:0] opm [0:40];
      int nacc, nres;
      bit load_next;
      nacc = 0; nres = 0; load_next = 1'b0;
      acc[0] = 0; acc[1] = 0;
      got_res[0] = '0; got_res[1] = '0; got_rd[0] = '0; got_rd[1] = '0;
      wb_ready = 1'b1; stall_target = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd5; req_fn = 3'd0; req_a = 32'd3; req_b = 32'd5; req_rd = 5'd1;
      for (int c = 0; c <= 40; c++) begin
         if (wb_valid && nres < 2) begin
            got_res[nres] = wb_result; got_rd[nres] = wb_rd; nres++;
         end
         opm[c] = alu_op_mode;
         if (load_next) begin
            if (nacc == 1) begin
               req_a = 32'd11; req_b = 32'd13; req_rd = 5'd2;
            end else begin
               req_valid = 1'b0;
            end
            load_next = 1'b0;
         end
         if (req_valid && req_ready && nacc < 2) begin
            acc[nacc] = c; nacc++; load_next = 1'b1;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      checks++; if (nacc !== 2 || acc[1] - acc[0] !== 4) begin errors++; $display("FAIL b2b_spacing got %0d accepts gap %0d exp 2 accepts gap 4", nacc, acc[1] - acc[0]); end
      checks++; if (nres !== 2 || got_res[0] !== 32'd15 || got_rd[0] !== 5'd1) begin errors++; $display("FAIL b2b_first got n=%0d res=%0d rd=%0d exp 15 rd=1", nres, got_res[0], got_rd[0]); end
      checks++; if (got_res[1] !== 32'd143 || got_rd[1] !== 5'd2) begin errors++; $display("FAIL b2b_second got res=%0d rd=%0d exp 143 rd=2", got_res[1], got_rd[1]); end
      checks++; if (opm[acc[0]+1] !== 3'd5 || opm[acc[0]+2] !== 3'd0 || opm[acc[0]+3] !== 3'd0 || opm[acc[1]+1] !== 3'd5) begin
         errors++; $display("FAIL b2b_opmode got %0d,%0d,%0d,%0d exp 5,0,0,5", opm[acc[0]+1], opm[acc[0]+2], opm[acc[0]+3], opm[acc[1]+1]);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      do_op(3'd1, 3'd2, a, b, 5'd17, 0, 1'b0, 10);
      checks++; if (lat_o !== 3 || res_o !== (a ^ b) || rd_o !== 5'd17) begin errors++; $display("FAIL bp_result got lat=%0d res=%0h rd=%0d exp lat=3 res=%0h rd=17", lat_o, res_o, rd_o, a ^ b); end
      checks++; if (bp_bad !== 0 || hold_tr[lat_o] !== 1'b1) begin errors++; $display("FAIL bp_stable got %0d unstable cycles hold=%b exp 0 and 1", bp_bad, hold_tr[lat_o]); end
      checks++; if (post_valid !== 1'b0 || post_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", post_valid, post_ready); end
   endtask

   task automatic test_random();
      logic [2:0] op, fn;
      logic [31:0] a, b, exp_res;
      logic [4:0] rd;
      int st, bp;
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 7)); fn = 3'($urandom_range(0, 7));
         a = $urandom; b = $urandom; rd = 5'($urandom_range(0, 31));
         if (op == 3'd6) b = b | 32'd1;
         st = (op == 3'd5 || op == 3'd6) ? $urandom_range(0, 5) : 0;
         bp = $urandom_range(0, 3);
         exp_res = ref_alu(op, fn, a, b);
         do_op(op, fn, a, b, rd, st, 1'b0, bp);
         checks++;
         if (lat_o !== 3 + st || res_o !== exp_res || rd_o !== rd || err_o !== 1'b0 || bp_bad !== 0 || post_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_op%0d got lat=%0d res=%0h rd=%0d err=%b bp=%0d pv=%b exp lat=%0d res=%0h rd=%0d err=0 bp=0 pv=0",
                     op, lat_o, res_o, rd_o, err_o, bp_bad, post_valid, 3 + st, exp_res, rd);
         end
      end
   endtask

   task automatic test_timeout();
      int n6;
      // stall drops in the limit cycle: completes without error
      do_op(3'd6, 3'd0, 32'd100, 32'd7, 5'd4, 7, 1'b0, 0);
      checks++; if (lat_o !== 10 || res_o !== 32'd14 || err_o !== 1'b0 || timeout_seen !== 1'b0) begin
         errors++; $display("FAIL to_edge got lat=%0d res=%0d err=%b seen=%b exp lat=10 res=14 err=0 seen=0", lat_o, res_o, err_o, timeout_seen);
      end
      do_op(3'd6, 3'd0, 32'd100, 32'd7, 5'd5, 0, 1'b1, 0);
      n6 = 0;
      for (int k = 1; k <= 8; k++) if (opm_tr[k] == 3'd6) n6++;
      checks++; if (lat_o !== 10) begin errors++; $display("FAIL to_lat got %0d exp 10", lat_o); end
      checks++; if (err_o !== 1'b1 || res_o !== 32'd0 || rd_o !== 5'd5) begin errors++; $display("FAIL to_result got err=%b res=%0h rd=%0d exp err=1 res=0 rd=5", err_o, res_o, rd_o); end
      checks++; if (n6 !== 8 || timeout_seen !== 1'b1) begin errors++; $display("FAIL to_exec got %0d exec cycles seen=%b exp 8 seen=1", n6, timeout_seen); end
      do_op(3'd4, 3'd1, 32'd50, 32'd8, 5'd6, 0, 1'b0, 0);
      checks++; if (res_o !== 32'd42 || err_o !== 1'b0 || timeout_seen !== 1'b1) begin errors++; $display("FAIL to_sticky got res=%0d err=%b seen=%b exp res=42 err=0 seen=1", res_o, err_o, timeout_seen); end
   endtask

   task automatic test_reset_mid_exec();
      int stray;
      stall_target = 20;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd6; req_fn = 3'd0; req_a = 32'd99; req_b = 32'd3; req_rd = 5'd8;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (alu_op_mode !== 3'd6) begin errors++; $display("FAIL mid_exec_setup got op=%0d exp 6", alu_op_mode); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if ({req_ready, alu_op_mode, alu_a, alu_b, alu_hold, wb_valid, wb_err, timeout_seen} !== 72'd0 || wb_result !== 32'd0 || wb_rd !== 5'd0) begin
         errors++; $display("FAIL mid_rst_state got rdy=%b op=%0d a=%0h v=%b seen=%b res=%0h rd=%0d exp all 0", req_ready, alu_op_mode, alu_a, wb_valid, timeout_seen, wb_result, wb_rd);
      end
      rst_n = 1'b1;
      stall_target = 0;
      stray = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (wb_valid) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL mid_rst_stray got %0d valid cycles exp 0", stray); end
      do_op(3'd4, 3'd0, 32'd1000, 32'd234, 5'd30, 0, 1'b0, 0);
      checks++; if (lat_o !== 3 || res_o !== 32'd1234 || rd_o !== 5'd30 || err_o !== 1'b0) begin
         errors++; $display("FAIL mid_rst_after got lat=%0d res=%0d rd=%0d err=%b exp lat=3 res=1234 rd=30 err=0", lat_o, res_o, rd_o, err_o);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul_stall();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_timeout();
      test_reset_mid_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue controller that is the requesting side of the ALU operation interface. It accepts one decoded operation from the decode stage through a valid/ready handshake and holds the operation and operands stable on the ALU. It waits out the ALU stall for multi-cycle mul/div, captures the registered ALU result, and returns it with its destination tag to writeback through a valid/ready handshake. A cycle-count timeout flags an ALU that never releases stall.

Parameters:
TIMEOUT_CYCLES, 64, maximum EXEC cycles with i_alu_stall high before the operation is aborted with error (minimum 2)
CNT_W, 7, width of the EXEC cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_req_valid  in  1  decode presents an operation
o_req_ready  out  1  controller accepts an operation this cycle
i_req_op_mode  in  3  ALU op mode (0 idle/pass, 1 logic, 2 shift, 3 compare, 4 add/sub, 5 mul, 6 div)
i_req_func_op  in  3  ALU functional option
i_req_a  in  32  operand a
i_req_b  in  32  operand b
i_req_rd  in  5  destination register tag
o_alu_op_mode  out  3  op mode to ALU
o_alu_func_op  out  3  func op to ALU
o_alu_fp_mode  out  1  constant 0 (integer only)
o_alu_hold  out  1  drives ALU stall input (freezes ALU result register)
o_alu_a  out  32  operand a to ALU
o_alu_b  out  32  operand b to ALU
i_alu_stall  in  1  ALU busy (combinational from ALU)
i_alu_result  in  32  ALU registered result
o_wb_valid  out  1  result available to writeback
i_wb_ready  in  1  writeback accepts result
o_wb_result  out  32  captured result
o_wb_rd  out  5  destination tag of result
o_wb_err  out  1  result is from a timed-out operation
o_timeout_seen  out  1  sticky: any timeout since reset

Behaviour:
- Reset is synchronous, active-low, sampled at posedge i_clk. It is honoured mid-operation: FSM goes to IDLE and all latched state clears. Reset values: o_req_ready=0 during reset and 1 in the first IDLE cycle after reset, o_alu_op_mode=0, o_alu_func_op=0, o_alu_a=o_alu_b=0, o_alu_hold=0, o_wb_valid=0, o_wb_result=0, o_wb_rd=0, o_wb_err=0, o_timeout_seen=0, counter=0.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE: o_req_ready=1. ALU outputs are op_mode=0 with operands 0. When i_req_valid=1, latch op_mode, func_op, a, b and rd, clear the counter, and go to EXEC.
- EXEC: drive the latched fields to the ALU; o_alu_hold=0.
  - If i_alu_stall=0 this cycle, go to CAPT (ALU registers its result at this edge).
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with stall still high, set the err flag and o_timeout_seen, and go to CAPT.
- CAPT: o_alu_op_mode=0 and operands 0. This lets ALU mul/div valid edge detection re-arm, so back-to-back mul or div operations each produce a fresh start. At the edge ending CAPT:
  - o_wb_result <= i_alu_result, or 0 if err.
  - o_wb_rd <= latched rd.
  - o_wb_err <= err.
  - Go to RESP.
- RESP: o_wb_valid=1; o_wb_result, o_wb_rd and o_wb_err are held stable. o_alu_hold=1 and op_mode=0. When i_wb_ready=1, go to IDLE; o_wb_valid drops the next cycle and err clears.
- o_req_ready is high only in IDLE, so no new request is accepted while one is in flight.
- Latency, request accept edge to o_wb_valid high:
  - single-cycle ops: 3 cycles
  - stalling ops: 3 + N cycles, where N = number of EXEC cycles with stall high
- Peak throughput: one operation per 4 cycles with i_wb_ready held at 1.
- op_mode 0 and 7 are forwarded unchanged. The ALU returns a, so the result equals i_req_a.
- Simultaneous events:
  - i_wb_ready held high before RESP: accepted in the first RESP cycle.
  - i_req_valid high during EXEC, CAPT or RESP: ignored, since ready is 0. Decode must hold the request.
  - i_alu_stall dropping in the same cycle the counter hits the limit: completion wins, no error.
- o_timeout_seen clears only on reset.

Test Plan:
- Reset, then add: request op=4, func=0, a=5, b=7, rd=3 with ALU model result 12 one cycle after EXEC → o_wb_valid high exactly 3 cycles after accept, result=12, rd=3, err=0. o_req_ready low for those cycles.
- Mul stall: op=5, a=6, b=7, model stall high for 4 EXEC cycles → op_mode=5 held for 5 cycles, then 0 in CAPT. Result 42 valid 7 cycles after accept.
- Back-to-back mul: two mul requests, i_wb_ready=1 → op_mode shows 5,0,0,5 pattern (0 in CAPT/RESP between them). Each operation gets its own result. Second accept occurs 4 cycles after the first at minimum stall.
- Writeback backpressure: i_wb_ready=0 for 10 cycles in RESP → result, rd and valid stable, o_alu_hold=1 throughout. Release completes in 1 cycle, then ready=1.
- Timeout: TIMEOUT_CYCLES=8, div with stall stuck high → after 8 EXEC cycles, o_wb_err=1, result=0, o_timeout_seen=1 and stays 1 across later good operations.
- Reset mid-EXEC of a div → next cycle all outputs at reset values. No o_wb_valid for the aborted operation. A new add completes normally.
